// File: rtl/dp_pkg.sv
// dp_pkg: definitions shared by the dual-port datapath arbiter.
//   OPCODE_W        : opcode width
//   opcode_e        : ADD=0001, SUB=0010, GCD=0011 (all other codes are invalid)
//   state_e         : arbiter FSM states IDLE / EXECUTE / RESPOND
//   is_valid_opcode : 1 for the three supported opcodes
package dp_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_GCD = 4'b0011
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXECUTE = 2'd1,
    RESPOND = 2'd2
  } state_e;

  function automatic logic is_valid_opcode(input logic [OPCODE_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_GCD);
  endfunction

endpackage

// File: rtl/dp_arbiter_rr_arb2.sv
// rr_arb2: two-requester winner select with a priority pointer.
//   clk, reset : clock, synchronous active-high reset (pointer -> 0)
//   req        : request vector
//   advance    : high for the single RESPOND cycle of a transaction
//   served     : index of the requester being answered
//   win_idx    : combinational winner (sole requester, or pointer on a tie)
//   ptr        : current priority pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic       win_idx,
  output logic       ptr
);

  always_comb begin
    win_idx = 1'b0;
    if (req == 2'b10) begin
      win_idx = 1'b1;
    end else if (req == 2'b11) begin
      win_idx = ptr;
    end
  end

  // After every response the other requester gets priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~served;
    end
  end

endmodule

// File: rtl/dp_arbiter.sv
// dp_arbiter: arbitrates two requesters onto one shared datapath.
//   Build option: define DP_ARBITER_TIMEOUT_EN to add an EXECUTE watchdog of
//   TIMEOUT cycles; without it EXECUTE waits for dp_done indefinitely.
//   clk, reset          : clock, synchronous active-high reset
//   req/req_opcode/req_a/req_b : per-requester request, held until rsp_valid
//   gnt                 : one-hot owner during EXECUTE/RESPOND, 0 in IDLE
//   rsp_valid           : one-cycle completion pulse for the winner
//   rsp_result/rsp_error: response payload, held outside RESPOND
//   err_count           : saturating count of error responses
//   dp_enable/dp_opcode/dp_a/dp_b : datapath command (operands latched in IDLE)
//   dp_done/dp_result   : datapath completion, only sampled in EXECUTE
// Handshake: a requester raises req with its operands and keeps it high until
// its rsp_valid bit pulses; dropping req early does not cancel the operation.
// The FSM state is visible as state_q for debug.
module dp_arbiter
  import dp_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int OPND    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               req,
  input  logic [1:0][OPCODE_W-1:0] req_opcode,
  input  logic [1:0][OPND-1:0]     req_a,
  input  logic [1:0][OPND-1:0]     req_b,
  output logic [1:0]               gnt,
  output logic [1:0]               rsp_valid,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_error,
  output logic [7:0]               err_count,
  output logic                     dp_enable,
  output logic [OPCODE_W-1:0]      dp_opcode,
  output logic [OPND-1:0]          dp_a,
  output logic [OPND-1:0]          dp_b,
  input  logic                     dp_done,
  input  logic [WIDTH-1:0]         dp_result
);

  state_e state_q, state_d;
  logic   win_q;
  logic   arb_win;
  logic   arb_ptr;
  logic   timeout_hit;
  logic   win_valid_op;
  logic   win_onehot_unused;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (state_q == RESPOND),
    .served  (win_q),
    .win_idx (arb_win),
    .ptr     (arb_ptr)
  );

  // The pointer is only consumed inside the arbiter; kept visible for debug.
  assign win_onehot_unused = arb_ptr;

  assign win_valid_op = is_valid_opcode(req_opcode[arb_win]);

`ifdef DP_ARBITER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] tmr_q;

  // Cleared when EXECUTE is entered, then counts every EXECUTE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q <= '0;
    end else if (state_q == IDLE) begin
      tmr_q <= '0;
    end else if (state_q == EXECUTE) begin
      tmr_q <= tmr_q + 1'b1;
    end
  end

  // True during the TIMEOUT-th EXECUTE cycle.
  assign timeout_hit = (tmr_q == TMR_W'(TIMEOUT - 1));
`else
  // Watchdog compiled out; the parameter is referenced only as a constant.
  assign timeout_hit = 1'b0 && (TIMEOUT > 0);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = win_valid_op ? EXECUTE : RESPOND;
        end
      end
      EXECUTE: begin
        if (dp_done || timeout_hit) begin
          state_d = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q      <= 1'b0;
      dp_opcode  <= '0;
      dp_a       <= '0;
      dp_b       <= '0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
      err_count  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            win_q     <= arb_win;
            dp_opcode <= req_opcode[arb_win];
            dp_a      <= req_a[arb_win];
            dp_b      <= req_b[arb_win];
            if (!win_valid_op) begin
              rsp_result <= '0;
              rsp_error  <= 1'b1;
            end
          end
        end
        EXECUTE: begin
          // A real completion wins over a watchdog expiry in the same cycle.
          if (dp_done) begin
            rsp_result <= dp_result;
            rsp_error  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_result <= '0;
            rsp_error  <= 1'b1;
          end
        end
        RESPOND: begin
          if (rsp_error && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt       = 2'b00;
    rsp_valid = 2'b00;
    dp_enable = 1'b0;
    if (state_q != IDLE) begin
      gnt = win_q ? 2'b10 : 2'b01;
    end
    if (state_q == RESPOND) begin
      rsp_valid = win_q ? 2'b10 : 2'b01;
    end
    if (state_q == EXECUTE) begin
      dp_enable = 1'b1;
    end
  end

endmodule

// File: tb/tb_dp_arbiter.sv
// tb_dp_arbiter: directed self-checking bench for dp_arbiter.
// Build with DP_ARBITER_TIMEOUT_EN defined to include the watchdog steps.
module tb_dp_arbiter;

  localparam int WIDTH   = 16;
  localparam int OPND    = 8;
  localparam int TIMEOUT = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]           req;
  logic [1:0][3:0]      req_opcode;
  logic [1:0][OPND-1:0] req_a;
  logic [1:0][OPND-1:0] req_b;
  logic [1:0]           gnt;
  logic [1:0]           rsp_valid;
  logic [WIDTH-1:0]     rsp_result;
  logic                 rsp_error;
  logic [7:0]           err_count;
  logic                 dp_enable;
  logic [3:0]           dp_opcode;
  logic [OPND-1:0]      dp_a;
  logic [OPND-1:0]      dp_b;
  logic                 dp_done;
  logic [WIDTH-1:0]     dp_result;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_err = 0;
  int pulses  = 0;

  logic [1:0] exp_gnt [12] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                               2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
  logic [1:0] exp_rsp [12] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00,
                               2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
  logic       exp_en  [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                               1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  dp_arbiter #(.WIDTH(WIDTH), .OPND(OPND), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_error  (rsp_error),
    .err_count  (err_count),
    .dp_enable  (dp_enable),
    .dp_opcode  (dp_opcode),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_done    (dp_done),
    .dp_result  (dp_result)
  );

  // driver: advance one clock, land 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    req        = 2'b00;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    dp_done    = 1'b0;
    dp_result  = '0;
    tick();
    tick();

    // reset values
    check("rst_gnt",       32'(gnt),        32'h0);
    check("rst_rsp_valid", 32'(rsp_valid),  32'h0);
    check("rst_dp_enable", 32'(dp_enable),  32'h0);
    check("rst_rsp_error", 32'(rsp_error),  32'h0);
    check("rst_err_count", 32'(err_count),  32'h0);
    check("rst_result",    32'(rsp_result), 32'h0);
    check("rst_dp_opcode", 32'(dp_opcode),  32'h0);
    check("rst_dp_a",      32'(dp_a),       32'h0);
    check("rst_dp_b",      32'(dp_b),       32'h0);
    reset = 1'b0;
    tick();
    check("idle_stay_gnt", 32'(gnt), 32'h0);

    // single request: dp_done on the 2nd EXECUTE cycle
    req           = 2'b01;
    req_opcode[0] = 4'b0001;
    req_a[0]      = 8'd5;
    req_b[0]      = 8'd3;
    req_opcode[1] = 4'hF;
    req_a[1]      = 8'hEE;
    tick();
    check("single_c1_gnt",    32'(gnt),       32'h1);
    check("single_c1_en",     32'(dp_enable), 32'h1);
    check("single_c1_opcode", 32'(dp_opcode), 32'h1);
    check("single_c1_a",      32'(dp_a),      32'd5);
    check("single_c1_b",      32'(dp_b),      32'd3);
    req_a[0]      = 8'h99;
    req_b[0]      = 8'h77;
    req_opcode[0] = 4'b0011;
    tick();
    check("single_c2_en",     32'(dp_enable), 32'h1);
    check("single_c2_a_held", 32'(dp_a),      32'd5);
    check("single_c2_op_held", 32'(dp_opcode), 32'h1);
    dp_done   = 1'b1;
    dp_result = 16'd8;
    tick();
    check("single_c3_rsp_valid", 32'(rsp_valid),  32'h1);
    check("single_c3_result",    32'(rsp_result), 32'd8);
    check("single_c3_error",     32'(rsp_error),  32'h0);
    check("single_c3_en",        32'(dp_enable),  32'h0);
    check("single_c3_gnt",       32'(gnt),        32'h1);
    req     = 2'b00;
    dp_done = 1'b0;
    tick();
    check("single_c4_rsp_valid", 32'(rsp_valid),  32'h0);
    check("single_c4_gnt",       32'(gnt),        32'h0);
    check("single_c4_hold",      32'(rsp_result), 32'd8);

    // tie after requester 0 was served: pointer now favours requester 1
    req           = 2'b11;
    req_opcode[0] = 4'b0010;
    req_opcode[1] = 4'b0010;
    dp_done       = 1'b1;
    dp_result     = 16'h00AA;
    tick();
    check("tie_gnt", 32'(gnt), 32'h2);
    tick();
    check("tie_rsp_valid", 32'(rsp_valid), 32'h2);
    req     = 2'b00;
    dp_done = 1'b0;
    tick();
    check("tie_idle_gnt", 32'(gnt), 32'h0);

    // contention from reset with dp_done held high
    reset         = 1'b1;
    req           = 2'b11;
    req_opcode[0] = 4'b0001;
    req_opcode[1] = 4'b0010;
    dp_done       = 1'b1;
    dp_result     = 16'h1234;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("cont_gnt_%0d", i),       32'(gnt),       32'(exp_gnt[i]));
      check($sformatf("cont_rsp_valid_%0d", i), 32'(rsp_valid), 32'(exp_rsp[i]));
      check($sformatf("cont_en_%0d", i),        32'(dp_enable), 32'(exp_en[i]));
      if (i == 1) check("cont_result", 32'(rsp_result), 32'h1234);
    end
    req     = 2'b00;
    dp_done = 1'b0;
    tick();
    check("cont_end_gnt", 32'(gnt), 32'h0);

`ifdef DP_ARBITER_TIMEOUT_EN
    // watchdog: dp_done never arrives
    req           = 2'b01;
    req_opcode[0] = 4'b0001;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("to_exec_en_%0d", i),  32'(dp_enable), 32'h1);
      check($sformatf("to_exec_rsp_%0d", i), 32'(rsp_valid), 32'h0);
    end
    tick();
    check("to_rsp_valid", 32'(rsp_valid),  32'h1);
    check("to_rsp_error", 32'(rsp_error),  32'h1);
    check("to_result",    32'(rsp_result), 32'h0);
    req = 2'b00;
    tick();
    exp_err++;
    check("to_err_count", 32'(err_count), 32'(exp_err));
`endif

    // invalid opcode goes straight to RESPOND
    req           = 2'b10;
    req_opcode[1] = 4'b1011;
    tick();
    check("inv_rsp_valid", 32'(rsp_valid),  32'h2);
    check("inv_rsp_error", 32'(rsp_error),  32'h1);
    check("inv_result",    32'(rsp_result), 32'h0);
    check("inv_en",        32'(dp_enable),  32'h0);
    check("inv_gnt",       32'(gnt),        32'h2);
    check("inv_opcode",    32'(dp_opcode),  32'hB);
    req = 2'b00;
    tick();
    exp_err++;
    check("inv_idle_rsp",  32'(rsp_valid), 32'h0);
    check("inv_idle_en",   32'(dp_enable), 32'h0);
    check("inv_err_count", 32'(err_count), 32'(exp_err));
    check("inv_err_hold",  32'(rsp_error), 32'h1);

    // reset in the 3rd EXECUTE cycle
    req           = 2'b01;
    req_opcode[0] = 4'b0010;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("rmid_en_%0d", i), 32'(dp_enable), 32'h1);
    end
    reset   = 1'b1;
    dp_done = 1'b1;
    tick();
    check("rmid_en",        32'(dp_enable), 32'h0);
    check("rmid_gnt",       32'(gnt),       32'h0);
    check("rmid_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rmid_err_count", 32'(err_count), 32'h0);
    reset   = 1'b0;
    req     = 2'b00;
    dp_done = 1'b0;
    tick();
    check("rmid_after_rsp", 32'(rsp_valid), 32'h0);
    check("rmid_after_en",  32'(dp_enable), 32'h0);

    // error counter saturation: 300 back-to-back invalid requests
    req           = 2'b01;
    req_opcode[0] = 4'b0000;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (rsp_valid == 2'b01) pulses++;
      tick();
      if (n == 254) check("sat_254", 32'(err_count), 32'd254);
      if (n == 255) check("sat_255", 32'(err_count), 32'd255);
      if (n == 300) check("sat_300", 32'(err_count), 32'd255);
    end
    req = 2'b00;
    tick();
    check("sat_pulses", 32'(pulses),    32'd300);
    check("sat_final",  32'(err_count), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
